mem_access_ctrl: RTL and testbench



---
 rtl/mem_pkg.sv | 31 +++
 rtl/load_extend.sv | 27 ++
 rtl/mem_access_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the load/store memory sequencer: access sizes (equal to
// the RAM op_code), response error codes, sequencer states and a legality check.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    STROBE = 2'b10,
    RESP   = 2'b11
  } state_e;

  // Only the two low address bits matter: halfwords need even, words 4-byte alignment.
  function automatic logic req_legal(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~addr_lo[0];
      SIZE_WORD: return (addr_lo == 2'b00);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Right-justified load data extension: byte/halfword are zero- or sign-extended,
// words pass through unchanged. Purely combinational so the writeback stage can reuse it.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_result
);

  logic w_sbyte;
  logic w_shalf;

  assign w_sbyte = i_signed & i_rdata[7];
  assign w_shalf = i_signed & i_rdata[15];

  always_comb begin
    o_result = i_rdata;
    case (i_size)
      SIZE_BYTE: o_result = {{24{w_sbyte}}, i_rdata[7:0]};
      SIZE_HALF: o_result = {{16{w_shalf}}, i_rdata[15:0]};
      default:   o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer in front of the big-endian byte RAM: accepts one request,
// checks alignment, strobes the RAM with stable setup, and returns a one-cycle response.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int READ_WAIT   = 2,
  parameter int MOC_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              mem_enable,
  output logic              mem_w_r,
  output logic [1:0]        mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_moc
);

  localparam int CNT_MAX = (READ_WAIT > MOC_TIMEOUT) ? READ_WAIT : MOC_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_write;
  logic                r_signed;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [31:0]         r_rsp_rdata;
  logic [1:0]          r_rsp_err;
  logic                r_mem_enable;
  logic                r_mem_w_r;
  logic [1:0]          r_mem_op;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic [31:0]         w_ext;
  logic                w_legal;

  assign w_legal = req_legal(req_size, req_addr[1:0]);

  // mem_op doubles as the latched access size for the extender.
  load_extend u_ext (
    .i_rdata  (mem_rdata),
    .i_size   (r_mem_op),
    .i_signed (r_signed),
    .o_result (w_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_signed     <= 1'b0;
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= ERR_OK;
      r_mem_enable <= 1'b0;
      r_mem_w_r    <= 1'b1;
      r_mem_op     <= SIZE_WORD;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_req_ready <= 1'b0;
            if (!w_legal) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= ERR_ALIGN;
              r_rsp_rdata <= '0;
            end else begin
              // RAM pins settle here while enable is still low; w_r never moves under enable.
              r_state     <= SETUP;
              r_write     <= req_write;
              r_signed    <= req_signed;
              r_mem_op    <= req_size;
              r_mem_addr  <= req_addr;
              r_mem_wdata <= req_wdata;
              r_mem_w_r   <= ~req_write;
            end
          end
        end
        SETUP: begin
          r_state      <= STROBE;
          r_cnt        <= '0;
          r_mem_enable <= 1'b1;
        end
        STROBE: begin
          if (!r_write) begin
            if (r_cnt == CNT_W'(READ_WAIT - 1)) begin
              r_state      <= RESP;
              r_mem_enable <= 1'b0;
              r_rsp_valid  <= 1'b1;
              r_rsp_err    <= ERR_OK;
              r_rsp_rdata  <= w_ext;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (mem_moc) begin
            r_state      <= RESP;
            r_mem_enable <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_err    <= ERR_OK;
            r_rsp_rdata  <= '0;
          end else if (r_cnt == CNT_W'(MOC_TIMEOUT - 1)) begin
            r_state      <= RESP;
            r_mem_enable <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_err    <= ERR_TIMEOUT;
            r_rsp_rdata  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_mem_w_r   <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_err    = r_rsp_err;
  assign mem_enable = r_mem_enable;
  assign mem_w_r    = r_mem_w_r;
  assign mem_op     = r_mem_op;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a pin-level big-endian RAM model answers the
// DUT, while a byte-array reference model predicts every response pushed to the queue.
module tb_mem_access_ctrl;

  localparam int ADDR_W      = 8;
  localparam int READ_WAIT   = 2;
  localparam int MOC_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        mem_enable;
  logic        mem_w_r;
  logic [1:0]  mem_op;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_moc = 1'b0;

  mem_access_ctrl #(
    .ADDR_W      (ADDR_W),
    .READ_WAIT   (READ_WAIT),
    .MOC_TIMEOUT (MOC_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_enable (mem_enable),
    .mem_w_r    (mem_w_r),
    .mem_op     (mem_op),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_moc    (mem_moc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- pin-level RAM model ----------------
  logic [7:0] ram_mem [256];
  bit         ram_init = 1'b0;
  int         en_cnt = 0;
  int         moc_delay = 1;
  bit         moc_kill = 1'b0;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 8'(i * 37 + 5);
      ram_init <= 1'b1;
    end
    if (mem_enable) begin
      en_cnt <= en_cnt + 1;
      if (!mem_w_r && !moc_kill && (en_cnt + 1 == moc_delay)) begin
        mem_moc <= 1'b1;
        case (mem_op)
          2'b00: ram_mem[mem_addr] <= mem_wdata[7:0];
          2'b01: begin
            ram_mem[mem_addr]        <= mem_wdata[15:8];
            ram_mem[mem_addr + 8'd1] <= mem_wdata[7:0];
          end
          default: begin
            ram_mem[mem_addr]        <= mem_wdata[31:24];
            ram_mem[mem_addr + 8'd1] <= mem_wdata[23:16];
            ram_mem[mem_addr + 8'd2] <= mem_wdata[15:8];
            ram_mem[mem_addr + 8'd3] <= mem_wdata[7:0];
          end
        endcase
      end
    end else begin
      en_cnt  <= 0;
      mem_moc <= 1'b0;
    end
  end

  always_comb begin
    mem_rdata = 32'h0;
    case (mem_op)
      2'b00:   mem_rdata = {24'h0, ram_mem[mem_addr]};
      2'b01:   mem_rdata = {16'h0, ram_mem[mem_addr], ram_mem[mem_addr + 8'd1]};
      default: mem_rdata = {ram_mem[mem_addr], ram_mem[mem_addr + 8'd1],
                            ram_mem[mem_addr + 8'd2], ram_mem[mem_addr + 8'd3]};
    endcase
  end

  // RAM pins must not move while enable is high, and w_r must not change on the enable edge.
  int         viol = 0;
  logic       prev_en = 1'b0;
  logic       prev_wr = 1'b1;
  logic [42:0] prev_bus = '0;
  always @(negedge clk) begin
    if (rst_n && mem_enable && (mem_w_r != prev_wr)) viol <= viol + 1;
    else if (rst_n && mem_enable && prev_en && ({mem_w_r, mem_op, mem_addr, mem_wdata} != prev_bus))
      viol <= viol + 1;
    prev_en  <= mem_enable;
    prev_wr  <= mem_w_r;
    prev_bus <= {mem_w_r, mem_op, mem_addr, mem_wdata};
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
    int          en;
    int          a;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ref_mem [256];

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit sg, input logic [7:0] ad);
    longint v = 0;
    int     nb = nbytes(sz);
    for (int i = 0; i < nb; i++) v = v * 256 + longint'(ref_mem[8'(ad + i)]);
    if (sg && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [7:0] ad, input logic [31:0] wd);
    int nb = nbytes(sz);
    for (int i = 0; i < nb; i++) ref_mem[8'(ad + i)] = 8'(wd >> (8 * (nb - 1 - i)));
  endtask

  function automatic bit ref_illegal(input logic [1:0] sz, input logic [7:0] ad);
    int a = int'(ad);
    return (sz == 2'b11) || (sz == 2'b01 && (a % 2) != 0) || (sz == 2'b10 && (a % 4) != 0);
  endfunction

  // Called from a negedge context; leaves the bench at the negedge after the accept edge.
  task automatic issue(input bit w, input logic [1:0] sz, input bit sg, input logic [7:0] ad,
                       input logic [31:0] wd, input int dly, input bit kill, input bit push);
    exp_t e;
    for (int k = 0; k < 200 && !req_ready; k++) @(negedge clk);
    if (!req_ready) begin
      chk("ready_wait_timeout", {31'h0, req_ready}, 32'h1);
      return;
    end
    if (ref_illegal(sz, ad)) begin
      e.rdata = 32'h0; e.err = 2'b01; e.lat = 1; e.en = 0;
    end else if (!w) begin
      e.rdata = ref_load(sz, sg, ad); e.err = 2'b00; e.lat = READ_WAIT + 2; e.en = READ_WAIT;
    end else if (kill) begin
      e.rdata = 32'h0; e.err = 2'b10; e.lat = MOC_TIMEOUT + 2; e.en = MOC_TIMEOUT;
    end else begin
      if (push) ref_store(sz, ad, wd);
      e.rdata = 32'h0; e.err = 2'b00; e.lat = dly + 3; e.en = dly + 1;
    end
    moc_delay  = dly;
    moc_kill   = kill;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = ad;
    req_wdata  = wd;
    req_valid  = 1'b1;
    e.a = cyc;
    if (push) sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 300 && (sb.size() != 0 || !req_ready); k++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_ready"},  {31'h0, req_ready},  32'h1);
    chk({tag, "_rsp_valid"},  {31'h0, rsp_valid},  32'h0);
    chk({tag, "_rsp_rdata"},  rsp_rdata,           32'h0);
    chk({tag, "_rsp_err"},    {30'h0, rsp_err},    32'h0);
    chk({tag, "_mem_enable"}, {31'h0, mem_enable}, 32'h0);
    chk({tag, "_mem_w_r"},    {31'h0, mem_w_r},    32'h1);
    chk({tag, "_mem_op"},     {30'h0, mem_op},     32'h2);
    chk({tag, "_mem_addr"},   {24'h0, mem_addr},   32'h0);
    chk({tag, "_mem_wdata"},  mem_wdata,           32'h0);
  endtask

  // ---------------- monitor ----------------
  int en_seen = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        en_seen = 0;
      end else if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", {31'h0, rsp_valid}, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", {30'h0, rsp_err}, {30'h0, e.err});
          chk("rsp_latency", 32'(cyc - e.a), 32'(e.lat));
          chk("enable_cycles", 32'(en_seen), 32'(e.en));
          chk("rsp_enable_low", {31'h0, mem_enable}, 32'h0);
          chk("rsp_ready_low", {31'h0, req_ready}, 32'h0);
          en_seen = 0;
          @(negedge clk);
          chk("post_ready", {31'h0, req_ready}, 32'h1);
          chk("post_w_r", {31'h0, mem_w_r}, 32'h1);
        end
      end else if (mem_enable) begin
        en_seen++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  sz;
    logic [7:0]  ad;
    bit          w;
    bit          kill;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 5);

    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // word store/load round trip and big-endian byte order in the RAM
    issue(1'b1, 2'b10, 1'b0, 8'h08, 32'hCACABABA, 3, 1'b0, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 8'h08, 32'h0, 1, 1'b0, 1'b1);
    wait_done();
    chk("plan_word_rdata", rsp_rdata, 32'hCACABABA);
    chk("ram_08", {24'h0, ram_mem[8'h08]}, 32'hCA);
    chk("ram_09", {24'h0, ram_mem[8'h09]}, 32'hCA);
    chk("ram_0A", {24'h0, ram_mem[8'h0A]}, 32'hBA);
    chk("ram_0B", {24'h0, ram_mem[8'h0B]}, 32'hBA);

    // byte sign/zero extension
    issue(1'b1, 2'b00, 1'b0, 8'h00, 32'h000000CC, 1, 1'b0, 1'b1);
    issue(1'b0, 2'b00, 1'b1, 8'h00, 32'h0, 1, 1'b0, 1'b1);
    wait_done();
    chk("plan_byte_signed", rsp_rdata, 32'hFFFFFFCC);
    issue(1'b0, 2'b00, 1'b0, 8'h00, 32'h0, 1, 1'b0, 1'b1);
    wait_done();
    chk("plan_byte_unsigned", rsp_rdata, 32'h000000CC);

    // halfword positive and negative signed loads; MOC on the last allowed cycle
    issue(1'b1, 2'b01, 1'b0, 8'h04, 32'h00007ABA, MOC_TIMEOUT - 1, 1'b0, 1'b1);
    issue(1'b0, 2'b01, 1'b1, 8'h04, 32'h0, 1, 1'b0, 1'b1);
    wait_done();
    chk("plan_half_pos", rsp_rdata, 32'h00007ABA);
    issue(1'b1, 2'b01, 1'b0, 8'h06, 32'h00008001, 2, 1'b0, 1'b1);
    issue(1'b0, 2'b01, 1'b1, 8'h06, 32'h0, 1, 1'b0, 1'b1);
    wait_done();
    chk("plan_half_neg", rsp_rdata, 32'hFFFF8001);

    // illegal requests, then MOC timeout, then a wrapping word access
    issue(1'b0, 2'b01, 1'b0, 8'h03, 32'h0, 1, 1'b0, 1'b1);
    issue(1'b1, 2'b10, 1'b0, 8'h06, 32'h12345678, 1, 1'b0, 1'b1);
    issue(1'b0, 2'b11, 1'b0, 8'h00, 32'h0, 1, 1'b0, 1'b1);
    issue(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 1, 1'b1, 1'b1);
    issue(1'b1, 2'b10, 1'b0, 8'hFC, 32'hA1B2C3D4, 4, 1'b0, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 8'hFC, 32'h0, 1, 1'b0, 1'b1);
    wait_done();

    // asynchronous reset in the middle of a strobe; the access is abandoned
    issue(1'b0, 2'b10, 1'b0, 8'h08, 32'h0, 1, 1'b0, 1'b0);
    for (int k = 0; k < 10 && !mem_enable; k++) @(negedge clk);
    chk("strobe_reached", {31'h0, mem_enable}, 32'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_state("midreset");
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 2'b10, 1'b0, 8'h08, 32'h0, 1, 1'b0, 1'b1);
    wait_done();
    chk("after_reset_word", rsp_rdata, 32'hCACABABA);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      w    = 1'($urandom % 2);
      sz   = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
      ad   = 8'($urandom);
      if ($urandom % 4 != 0) begin
        if (sz == 2'b01) ad[0] = 1'b0;
        if (sz == 2'b10) ad[1:0] = 2'b00;
      end
      kill = w && ($urandom % 10 == 0);
      issue(w, sz, 1'($urandom % 2), ad, $urandom,
            int'($urandom_range(1, MOC_TIMEOUT - 1)), kill, 1'b1);
    end
    wait_done();

    chk("sb_drained", 32'(sb.size()), 32'h0);
    chk("bus_stable_violations", 32'(viol), 32'h0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
